// File: rtl/post_code_scheduler_pkg.sv
// Shared types for the POST code scheduler: code width, FSM state encoding
// and the helper that forms a 16-bit code from the port 81h/80h bytes.
package post_code_scheduler_pkg;

    localparam int CODE_W = 16;

    typedef logic [CODE_W-1:0] post_code_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SEND  = 2'd2,
        ST_DWELL = 2'd3
    } sched_state_t;

    function automatic post_code_t pack_code(input logic [7:0] hi, input logic [7:0] lo);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/post_code_scheduler_if.sv
// Hit strobe from lpc_decode plus the valid/ready link to the display driver.
interface post_code_scheduler_if;

    logic                              code_hit;
    logic [7:0]                        code_80;
    logic [7:0]                        code_81;
    post_code_scheduler_pkg::post_code_t disp_code;
    logic                              disp_valid;
    logic                              disp_ready;

    modport master (
        output code_hit, code_80, code_81, disp_ready,
        input  disp_code, disp_valid
    );

    modport slave (
        input  code_hit, code_80, code_81, disp_ready,
        output disp_code, disp_valid
    );

endinterface

// File: rtl/post_code_scheduler_fifo.sv
// Synchronous DEPTH x 16 FIFO; a push while full is accepted when a pop
// happens in the same cycle.
module post_code_scheduler_fifo
    import post_code_scheduler_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     lpc_clk,
    input  logic                     lpc_rst,
    input  logic                     i_push,
    input  post_code_t               i_data,
    input  logic                     i_pop,
    output post_code_t               o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);

    post_code_t      r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_level;
    logic            w_push;
    logic            w_pop;

    assign o_empty = (r_level == '0);
    assign o_full  = (r_level == (AW+1)'(DEPTH));
    assign o_level = r_level;
    assign o_head  = r_mem[r_rd_ptr];

    assign w_pop  = i_pop & ~o_empty;
    assign w_push = i_push & (~o_full | w_pop);

    always_ff @(posedge lpc_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge lpc_clk) begin
        if (lpc_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/post_code_scheduler.sv
// Queues POST codes from lpc_decode and replays them to the display driver,
// holding each one for a minimum dwell so fast boot sequences stay readable.
//
//   state | meaning
//   IDLE  | waiting for a queued code; pops the head into the hold register
//   LOAD  | presents the held code on disp_code with disp_valid
//   SEND  | waits for disp_ready, then starts the dwell timer
//   DWELL | counts the timer down to zero while the display shows the code
module post_code_scheduler
    import post_code_scheduler_pkg::*;
#(
    parameter int DEPTH        = 8,
    parameter int DWELL_CYCLES = 33000,
    parameter bit DEDUP        = 1'b1
) (
    input  logic                     lpc_clk,
    input  logic                     lpc_rst,
    post_code_scheduler_if.slave     post_bus,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow,
    input  logic                     ovf_clr,
    output logic [7:0]               drop_count
);

    localparam int TW = (DWELL_CYCLES > 0) ? $clog2(DWELL_CYCLES + 1) : 1;
    localparam logic [TW-1:0] DWELL_LOAD = (DWELL_CYCLES > 0) ? TW'(DWELL_CYCLES - 1) : '0;

    sched_state_t  r_state, w_state_nxt;
    post_code_t    r_hold, w_hold_nxt;
    post_code_t    r_disp_code, w_disp_code_nxt;
    logic          r_disp_valid, w_disp_valid_nxt;
    logic [TW-1:0] r_timer, w_timer_nxt;

    post_code_t    r_last_code;
    logic          r_last_valid;
    logic          r_overflow;
    logic [7:0]    r_drop_count;

    post_code_t    w_code;
    post_code_t    w_head;
    logic          w_full;
    logic          w_empty;
    logic          w_dup;
    logic          w_qual;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;

    assign w_code = pack_code(post_bus.code_81, post_bus.code_80);
    assign w_dup  = DEDUP & r_last_valid & (w_code == r_last_code);
    assign w_qual = post_bus.code_hit & ~w_dup;
    assign w_push = w_qual & (~w_full | w_pop);
    assign w_drop = w_qual & w_full & ~w_pop;

    post_code_scheduler_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .lpc_clk (lpc_clk),
        .lpc_rst (lpc_rst),
        .i_push  (w_push),
        .i_data  (w_code),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (fifo_level)
    );

    always_comb begin
        w_state_nxt      = r_state;
        w_hold_nxt       = r_hold;
        w_disp_code_nxt  = r_disp_code;
        w_disp_valid_nxt = r_disp_valid;
        w_timer_nxt      = r_timer;
        w_pop            = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_hold_nxt  = w_head;
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_disp_code_nxt  = r_hold;
                w_disp_valid_nxt = 1'b1;
                w_state_nxt      = ST_SEND;
            end
            ST_SEND: begin
                if (r_disp_valid && post_bus.disp_ready) begin
                    w_disp_valid_nxt = 1'b0;
                    if (DWELL_CYCLES == 0) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_timer_nxt = DWELL_LOAD;
                        w_state_nxt = ST_DWELL;
                    end
                end
            end
            ST_DWELL: begin
                if (r_timer == '0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_timer_nxt = r_timer - 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge lpc_clk) begin
        if (lpc_rst) begin
            r_state      <= ST_IDLE;
            r_hold       <= '0;
            r_disp_code  <= '0;
            r_disp_valid <= 1'b0;
            r_timer      <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_hold       <= w_hold_nxt;
            r_disp_code  <= w_disp_code_nxt;
            r_disp_valid <= w_disp_valid_nxt;
            r_timer      <= w_timer_nxt;
        end
    end

    // A drop in the same cycle as ovf_clr keeps the flag set.
    always_ff @(posedge lpc_clk) begin
        if (lpc_rst) begin
            r_last_code  <= '0;
            r_last_valid <= 1'b0;
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else begin
            if (w_push) begin
                r_last_code  <= w_code;
                r_last_valid <= 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (ovf_clr) begin
                r_overflow <= 1'b0;
            end
            if (w_drop && (r_drop_count != 8'hFF)) begin
                r_drop_count <= r_drop_count + 8'd1;
            end
        end
    end

    assign post_bus.disp_code  = r_disp_code;
    assign post_bus.disp_valid = r_disp_valid;
    assign overflow            = r_overflow;
    assign drop_count          = r_drop_count;

endmodule

// File: tb/tb_post_code_scheduler.sv
// Directed bench for post_code_scheduler with DEPTH=4, DWELL_CYCLES=4; a second
// instance with DEDUP=0 covers the non-filtering configuration.
`timescale 1ns/1ps
module tb_post_code_scheduler;
    import post_code_scheduler_pkg::*;

    localparam int DEPTH = 4;
    localparam int DWELL = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    post_code_scheduler_if bus_a ();
    post_code_scheduler_if bus_b ();

    logic [LW-1:0] level_a, level_b;
    logic          ovf_a, ovf_b;
    logic          clr_a, clr_b;
    logic [7:0]    drop_a, drop_b;

    post_code_scheduler #(.DEPTH(DEPTH), .DWELL_CYCLES(DWELL), .DEDUP(1'b1)) dut_a (
        .lpc_clk(clk), .lpc_rst(rst), .post_bus(bus_a),
        .fifo_level(level_a), .overflow(ovf_a), .ovf_clr(clr_a), .drop_count(drop_a)
    );

    post_code_scheduler #(.DEPTH(DEPTH), .DWELL_CYCLES(DWELL), .DEDUP(1'b0)) dut_b (
        .lpc_clk(clk), .lpc_rst(rst), .post_bus(bus_b),
        .fifo_level(level_b), .overflow(ovf_b), .ovf_clr(clr_b), .drop_count(drop_b)
    );

    // Handshake log: every accepted code and the cycle it was accepted in.
    int         cyc = 0;
    post_code_t out_a[$];
    int         out_t[$];
    post_code_t out_b[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && bus_a.disp_valid && bus_a.disp_ready) begin
            out_a.push_back(bus_a.disp_code);
            out_t.push_back(cyc);
        end
        if (!rst && bus_b.disp_valid && bus_b.disp_ready) begin
            out_b.push_back(bus_b.disp_code);
        end
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [31:0] a_at(input int i);
        if (i < out_a.size()) return {16'h0, out_a[i]};
        return 32'hDEADBEEF;
    endfunction

    function automatic logic [31:0] b_at(input int i);
        if (i < out_b.size()) return {16'h0, out_b[i]};
        return 32'hDEADBEEF;
    endfunction

    function automatic int t_at(input int i);
        if (i < out_t.size()) return out_t[i];
        return -1000;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        out_a.delete();
        out_t.delete();
        out_b.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus_a.code_hit = 1'b0;
        bus_b.code_hit = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic hit_a(input logic [15:0] c);
        bus_a.code_hit = 1'b1;
        bus_a.code_81  = c[15:8];
        bus_a.code_80  = c[7:0];
        tick();
        bus_a.code_hit = 1'b0;
    endtask

    task automatic hit_both(input logic [15:0] c);
        bus_a.code_hit = 1'b1;
        bus_a.code_81  = c[15:8];
        bus_a.code_80  = c[7:0];
        bus_b.code_hit = 1'b1;
        bus_b.code_81  = c[15:8];
        bus_b.code_80  = c[7:0];
        tick();
        bus_a.code_hit = 1'b0;
        bus_b.code_hit = 1'b0;
    endtask

    typedef struct {
        logic [7:0]  c81;
        logic [7:0]  c80;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[4];

    initial begin
        vecs[0] = '{8'h12, 8'hA5, 16'h12A5};
        vecs[1] = '{8'hFF, 8'hFF, 16'hFFFF};
        vecs[2] = '{8'h00, 8'h01, 16'h0001};
        vecs[3] = '{8'h80, 8'h81, 16'h8081};

        bus_a.code_hit = 1'b0; bus_a.code_80 = '0; bus_a.code_81 = '0; bus_a.disp_ready = 1'b1;
        bus_b.code_hit = 1'b0; bus_b.code_80 = '0; bus_b.code_81 = '0; bus_b.disp_ready = 1'b1;
        clr_a = 1'b0;
        clr_b = 1'b0;

        do_reset();
        check("reset disp_valid", {31'h0, bus_a.disp_valid}, 32'h0);
        check("reset disp_code", {16'h0, bus_a.disp_code}, 32'h0);
        check("reset fifo_level", {29'h0, level_a}, 32'h0);
        check("reset overflow", {31'h0, ovf_a}, 32'h0);
        check("reset drop_count", {24'h0, drop_a}, 32'h0);

        // Single-code latency and dwell hold, one table row at a time.
        for (int i = 0; i < 4; i++) begin
            hit_a({vecs[i].c81, vecs[i].c80});
            check($sformatf("v%0d level after E0", i), {29'h0, level_a}, 32'h1);
            check($sformatf("v%0d valid after E0", i), {31'h0, bus_a.disp_valid}, 32'h0);
            tick();
            check($sformatf("v%0d level after E1", i), {29'h0, level_a}, 32'h0);
            check($sformatf("v%0d valid after E1", i), {31'h0, bus_a.disp_valid}, 32'h0);
            tick();
            check($sformatf("v%0d valid after E2", i), {31'h0, bus_a.disp_valid}, 32'h1);
            check($sformatf("v%0d code after E2", i), {16'h0, bus_a.disp_code}, {16'h0, vecs[i].exp});
            tick();
            check($sformatf("v%0d valid after E3", i), {31'h0, bus_a.disp_valid}, 32'h0);
            repeat (4) tick();
            check($sformatf("v%0d code held in dwell", i), {16'h0, bus_a.disp_code}, {16'h0, vecs[i].exp});
            repeat (2) tick();
        end

        // Back-to-back hits: FIFO order and exact DWELL+3 spacing.
        clear_logs();
        hit_a(16'h0001);
        hit_a(16'h0002);
        hit_a(16'h0003);
        repeat (30) tick();
        check("t2 count", out_a.size(), 32'd3);
        for (int i = 0; i < 3; i++) check($sformatf("t2 code%0d", i), a_at(i), 32'h1 + i);
        check("t2 spacing01", t_at(1) - t_at(0), DWELL + 3);
        check("t2 spacing12", t_at(2) - t_at(1), DWELL + 3);
        check("t2 level", {29'h0, level_a}, 32'h0);
        check("t2 overflow", {31'h0, ovf_a}, 32'h0);

        // Stalled display: fill, overflow by one, then drain.
        clear_logs();
        bus_a.disp_ready = 1'b0;
        for (int i = 0; i < 6; i++) hit_a(16'h0101 + 16'(i));
        check("t3 level", {29'h0, level_a}, 32'h4);
        check("t3 overflow", {31'h0, ovf_a}, 32'h1);
        check("t3 drop_count", {24'h0, drop_a}, 32'h1);
        repeat (3) tick();
        check("t3 valid held", {31'h0, bus_a.disp_valid}, 32'h1);
        check("t3 code held", {16'h0, bus_a.disp_code}, 32'h0101);
        bus_a.disp_ready = 1'b1;
        repeat (50) tick();
        check("t3 drained count", out_a.size(), 32'd5);
        for (int i = 0; i < 5; i++) check($sformatf("t3 code%0d", i), a_at(i), 32'h0101 + i);
        check("t3 level drained", {29'h0, level_a}, 32'h0);
        check("t3 overflow sticky", {31'h0, ovf_a}, 32'h1);
        clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        check("t3 ovf_clr clears", {31'h0, ovf_a}, 32'h0);
        check("t3 ovf_clr keeps count", {24'h0, drop_a}, 32'h1);

        // Dedup on instance a, no dedup on instance b.
        do_reset();
        clear_logs();
        hit_both(16'h0055);
        hit_both(16'h0055);
        hit_both(16'h0056);
        repeat (40) tick();
        check("t4 dedup count", out_a.size(), 32'd2);
        check("t4 dedup code0", a_at(0), 32'h0055);
        check("t4 dedup code1", a_at(1), 32'h0056);
        check("t4 dedup drops", {24'h0, drop_a}, 32'h0);
        check("t4 nodedup count", out_b.size(), 32'd3);
        check("t4 nodedup code0", b_at(0), 32'h0055);
        check("t4 nodedup code1", b_at(1), 32'h0055);
        check("t4 nodedup code2", b_at(2), 32'h0056);

        // Reset while in SEND with two codes queued.
        bus_a.disp_ready = 1'b0;
        hit_a(16'h0A01);
        hit_a(16'h0A02);
        hit_a(16'h0A03);
        tick();
        check("t5 valid before reset", {31'h0, bus_a.disp_valid}, 32'h1);
        check("t5 level before reset", {29'h0, level_a}, 32'h2);
        rst = 1'b1;
        tick();
        check("t5 valid after reset", {31'h0, bus_a.disp_valid}, 32'h0);
        check("t5 code after reset", {16'h0, bus_a.disp_code}, 32'h0);
        check("t5 level after reset", {29'h0, level_a}, 32'h0);
        rst = 1'b0;
        bus_a.disp_ready = 1'b1;
        clear_logs();
        hit_a(16'h0000);
        check("t5 zero pushed", {29'h0, level_a}, 32'h1);
        repeat (10) tick();
        check("t5 zero count", out_a.size(), 32'd1);
        check("t5 zero code", a_at(0), 32'h0000);

        // ovf_clr versus drop priority and drop_count saturation.
        do_reset();
        bus_a.disp_ready = 1'b0;
        for (int i = 0; i < 5; i++) hit_a(16'h0601 + 16'(i));
        check("t6 full", {29'h0, level_a}, 32'h4);
        clr_a = 1'b1;
        hit_a(16'h06FF);
        clr_a = 1'b0;
        check("t6 set wins", {31'h0, ovf_a}, 32'h1);
        check("t6 drop with clr", {24'h0, drop_a}, 32'h1);
        clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        check("t6 clr alone", {31'h0, ovf_a}, 32'h0);
        check("t6 clr alone count", {24'h0, drop_a}, 32'h1);
        for (int i = 0; i < 259; i++) begin
            hit_a(16'h06FF);
            if (i == 252) check("t6 count 254", {24'h0, drop_a}, 32'd254);
        end
        check("t6 saturated", {24'h0, drop_a}, 32'hFF);
        check("t6 overflow set", {31'h0, ovf_a}, 32'h1);
        check("t6 level still full", {29'h0, level_a}, 32'h4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
